ex_flag_stage: RTL

//  Execute-stage back end. Sits directly downstream of the ALU.

---
 rtl/ex_flag_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: execute-stage back end sitting directly downstream of the ALU.
// It owns the architectural C/Z flags, applies conditional execution, registers
// the surviving instruction into the EX/MEM pipeline register, and keeps a
// saturating count of instructions squashed by a failed condition.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   valid_in            ALU stage holds a real instruction this cycle
//   alu_result          ALU output, bit DATA_W is the carry out
//   alu_z               ALU zero flag for alu_result[DATA_W-1:0]
//   cond_in             00 always, 10 if C, 01 if Z, 11 reserved (always)
//   c_wr_in, z_wr_in    instruction writes C / Z
//   rd_in, reg_wr_in    destination register and its write enable
//   mem_z_wr, mem_z_val older load in MEM updates Z this cycle, with this value
//   stall               hold this stage
//   flush               kill the instruction entering this stage (beats stall)
//   valid_out, result_out, rd_out, reg_wr_out   EX/MEM pipeline register
//   c_flag, z_flag      architectural flags
//   squash_cnt          saturating count of condition-failed instructions
module ex_flag_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DATA_W:0]   alu_result,
    input  logic              alu_z,
    input  logic [1:0]        cond_in,
    input  logic              c_wr_in,
    input  logic              z_wr_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              reg_wr_in,
    input  logic              mem_z_wr,
    input  logic              mem_z_val,
    input  logic              stall,
    input  logic              flush,
    output logic              valid_out,
    output logic [DATA_W-1:0] result_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              reg_wr_out,
    output logic              c_flag,
    output logic              z_flag,
    output logic [CNT_W-1:0]  squash_cnt
);

    localparam logic [1:0] COND_IF_Z = 2'b01;
    localparam logic [1:0] COND_IF_C = 2'b10;

    logic              z_eff;
    logic              cond_pass;
    logic              z_after_load;

    logic              valid_nxt;
    logic [DATA_W-1:0] result_nxt;
    logic [REG_AW-1:0] rd_nxt;
    logic              reg_wr_nxt;
    logic              c_nxt;
    logic              z_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    // Condition check sees the older load's Z when it lands this cycle.
    always_comb begin
        z_eff = mem_z_wr ? mem_z_val : z_flag;
        unique case (cond_in)
            COND_IF_Z: cond_pass = z_eff;
            COND_IF_C: cond_pass = c_flag;
            default:   cond_pass = 1'b1;
        endcase
    end

    // Z as updated by the older load only; the load is never stalled or flushed here.
    assign z_after_load = mem_z_wr ? mem_z_val : z_flag;

    // Next-state selection, in priority order: stall, flush, bubble, pass, squash.
    always_comb begin
        valid_nxt  = valid_out;
        result_nxt = result_out;
        rd_nxt     = rd_out;
        reg_wr_nxt = reg_wr_out;
        c_nxt      = c_flag;
        z_nxt      = z_after_load;
        cnt_nxt    = squash_cnt;

        if (stall && !flush) begin
            // everything holds except the older load's Z update
        end else if (flush || !valid_in) begin
            valid_nxt  = 1'b0;
            reg_wr_nxt = 1'b0;
        end else if (cond_pass) begin
            valid_nxt  = 1'b1;
            result_nxt = alu_result[DATA_W-1:0];
            rd_nxt     = rd_in;
            reg_wr_nxt = reg_wr_in;
            if (c_wr_in) begin
                c_nxt = alu_result[DATA_W];
            end
            // This instruction is younger than the load, so its Z wins.
            if (z_wr_in) begin
                z_nxt = alu_z;
            end
        end else begin
            // Retires as a NOP; result and rd still load for debug visibility.
            valid_nxt  = 1'b1;
            result_nxt = alu_result[DATA_W-1:0];
            rd_nxt     = rd_in;
            reg_wr_nxt = 1'b0;
            if (squash_cnt != {CNT_W{1'b1}}) begin
                cnt_nxt = squash_cnt + CNT_W'(1);
            end
        end
    end

    // EX/MEM pipeline register, flags and squash counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            result_out <= '0;
            rd_out     <= '0;
            reg_wr_out <= 1'b0;
            c_flag     <= 1'b0;
            z_flag     <= 1'b0;
            squash_cnt <= '0;
        end else begin
            valid_out  <= valid_nxt;
            result_out <= result_nxt;
            rd_out     <= rd_nxt;
            reg_wr_out <= reg_wr_nxt;
            c_flag     <= c_nxt;
            z_flag     <= z_nxt;
            squash_cnt <= cnt_nxt;
        end
    end

endmodule
